// File: rtl/pi_sequencer_pkg.sv
// Shared types and constants for the pi digit sequencer: state names,
// index/digit widths and the dwell table selected by rate_sel.
package pi_sequencer_pkg;

    localparam int IDX_W   = 9;
    localparam int DIG_W   = 4;
    localparam int DWELL_W = 16;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_BLANK = 3'd4
    } state_t;

    // Dwell table: digit shown for 16 / 256 / 4096 / 65536 clocks.
    // Returned as the last count value (length - 1) so it fits DWELL_W bits.
    function automatic logic [DWELL_W-1:0] dwell_last(input logic [1:0] rate_sel);
        logic [DWELL_W-1:0] last;
        case (rate_sel)
            2'd0:    last = 16'd15;
            2'd1:    last = 16'd255;
            2'd2:    last = 16'd4095;
            default: last = 16'hFFFF;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/pi_sequencer_if.sv
// Control, ROM and display signals of the pi digit sequencer.
// master = the environment driving controls and the ROM, slave = the sequencer.
interface pi_sequencer_if;
    import pi_sequencer_pkg::*;

    logic             load;
    logic [4:0]       load_data;
    logic             run;
    logic             step;
    logic [1:0]       rate_sel;
    logic [DIG_W-1:0] rom_hex;
    logic [IDX_W-1:0] rom_index;
    logic [DIG_W-1:0] digit;
    logic             digit_valid;
    logic             blank;
    logic             wrapped;

    modport master (
        output load, load_data, run, step, rate_sel, rom_hex,
        input  rom_index, digit, digit_valid, blank, wrapped
    );

    modport slave (
        input  load, load_data, run, step, rate_sel, rom_hex,
        output rom_index, digit, digit_valid, blank, wrapped
    );

endinterface

// File: rtl/pi_dwell_timer.sv
// Dwell prescaler: counts clocks a digit has been shown and flags when the
// length picked by rate_sel has been reached.
module pi_dwell_timer
    import pi_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [1:0] i_rate_sel,
    output logic       o_done
);

    logic [DWELL_W-1:0] r_count;

    // Count while enabled; cleared when a new digit is captured.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // ">=" so switching to a shorter dwell after it has already elapsed
    // still ends the digit on the very next clock.
    assign o_done = (r_count >= dwell_last(i_rate_sel));

endmodule

// File: rtl/pi_sequencer.sv
// Pi digit sequencer: walks a 9-bit ROM address, captures each digit after
// the ROM latency, shows it for a dwell period and blanks between digits.
// The start index can be loaded in 5-bit beats; wrap 511->0 is flagged.
module pi_sequencer
    import pi_sequencer_pkg::*;
#(
    parameter int BLANK_CYCLES = 4,
    parameter int ROM_LAT      = 1
)(
    input  logic           clk,
    input  logic           reset,
    pi_sequencer_if.slave  bus
);

    localparam logic [7:0] WAIT_LAST  = 8'(ROM_LAT - 1);
    localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_rom_index;
    logic [IDX_W-1:0] r_index_load;
    logic [DIG_W-1:0] r_digit;
    logic             r_wrapped;
    logic             r_step_d;
    logic [7:0]       r_wait_cnt;
    logic [3:0]       r_blank_cnt;

    logic w_step_rise;
    logic w_dwell_done;
    logic w_take_index;
    logic w_advance;
    logic w_capture;
    logic w_show;

    assign w_step_rise = bus.step & ~r_step_d;

    pi_dwell_timer u_dwell (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_capture),
        .i_en       (w_show & bus.run),
        .i_rate_sel (bus.rate_sel),
        .o_done     (w_dwell_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes; load overrides every state.
    always_comb begin
        w_state_nxt  = r_state;
        w_take_index = 1'b0;
        w_advance    = 1'b0;
        w_capture    = 1'b0;
        w_show       = (r_state == ST_SHOW);
        if (bus.load) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    w_state_nxt  = ST_FETCH;
                    w_take_index = 1'b1;
                end
                ST_FETCH: w_state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_nxt = ST_SHOW;
                        w_capture   = 1'b1;
                    end
                end
                ST_SHOW: begin
                    if ((bus.run && w_dwell_done) || (!bus.run && w_step_rise)) begin
                        w_state_nxt = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (r_blank_cnt == BLANK_LAST) begin
                        w_state_nxt = ST_FETCH;
                        w_advance   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end
    end

    // Phase length counters; restart whenever their phase is left.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt  <= '0;
            r_blank_cnt <= '0;
        end else begin
            r_wait_cnt  <= (r_state == ST_WAIT  && w_state_nxt == ST_WAIT)  ? r_wait_cnt + 1'b1  : '0;
            r_blank_cnt <= (r_state == ST_BLANK && w_state_nxt == ST_BLANK) ? r_blank_cnt + 1'b1 : '0;
        end
    end

    // Index load shift register, ROM address and sticky wrap flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_index_load <= '0;
            r_rom_index  <= '0;
            r_wrapped    <= 1'b0;
        end else begin
            if (bus.load) begin
                r_index_load <= {bus.load_data, r_index_load[8:5]};
            end
            if (w_take_index) begin
                r_rom_index <= r_index_load;
                r_wrapped   <= 1'b0;
            end else if (w_advance) begin
                r_rom_index <= r_rom_index + 1'b1;
                if (r_rom_index == '1) begin
                    r_wrapped <= 1'b1;
                end
            end
        end
    end

    // Digit capture at the end of the ROM wait, plus the step edge detector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_digit  <= '0;
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= bus.step;
            if (w_capture) begin
                r_digit <= bus.rom_hex;
            end
        end
    end

    assign bus.rom_index   = r_rom_index;
    assign bus.digit       = r_digit;
    assign bus.digit_valid = w_show;
    assign bus.blank       = ~w_show;
    assign bus.wrapped     = r_wrapped;

endmodule
